// File: rtl/ws281x_pkg.sv
// Shared definitions for the WS281x pixel serializer: FSM state encoding and default widths.
package ws281x_pkg;

    localparam int unsigned DEFAULT_PIXEL_BITS = 24;
    localparam int unsigned DEFAULT_RST_CNT_W  = 16;

    typedef logic [2:0] ws281x_ser_state_t;

    localparam ws281x_ser_state_t IDLE  = 3'd0;
    localparam ws281x_ser_state_t SEND  = 3'd1;
    localparam ws281x_ser_state_t WAIT  = 3'd2;
    localparam ws281x_ser_state_t LOAD  = 3'd3;
    localparam ws281x_ser_state_t LATCH = 3'd4;

endpackage

// File: rtl/ws281x_latch_timer.sv
// Loadable down-counter for the line-reset low period; expire is high in the final counted cycle.
module ws281x_latch_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // A load value of 0 still yields one expiring cycle once running.
    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/ws281x_pixel_ser.sv
// Pixel word to serial bit-request converter for ws281x_code, with end-of-frame latch period.
module ws281x_pixel_ser
    import ws281x_pkg::*;
#(
    parameter int unsigned PIXEL_BITS = DEFAULT_PIXEL_BITS,
    parameter int unsigned RST_CNT_W  = DEFAULT_RST_CNT_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  pixel_vld_in,
    input  logic [PIXEL_BITS-1:0] pixel_data_in,
    input  logic                  pixel_last_in,
    output logic                  pixel_rdy_out,
    input  logic [RST_CNT_W-1:0]  rst_cnt_in,
    input  logic                  bit_done_in,
    output logic                  bit_rdy_out,
    output logic                  bit_data_out,
    output logic                  frame_done_out,
    output logic                  underrun_out,
    output logic                  busy_out
);

    localparam int unsigned CNT_W = $clog2(PIXEL_BITS);

    ws281x_ser_state_t     state_q, state_d;
    logic [PIXEL_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  last_q;
    logic                  load_entry_q;
    logic                  xfer;
    logic                  pixel_done;
    logic                  latch_load;
    logic                  latch_expire;

    assign xfer       = pixel_vld_in && pixel_rdy_out;
    assign pixel_done = (bit_cnt_q == CNT_W'(PIXEL_BITS - 1));

    always_comb begin
        state_d    = state_q;
        latch_load = 1'b0;
        case (state_q)
            IDLE:  if (xfer) state_d = SEND;
            SEND:  state_d = WAIT;
            WAIT: begin
                if (bit_done_in) begin
                    if (!pixel_done) begin
                        state_d = SEND;
                    end else if (last_q) begin
                        state_d    = LATCH;
                        latch_load = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD:  if (xfer) state_d = SEND;
            LATCH: if (latch_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            last_q       <= 1'b0;
            load_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_entry_q <= (state_d == LOAD) && (state_q != LOAD);
            if (xfer) begin
                shift_q   <= pixel_data_in;
                bit_cnt_q <= '0;
                last_q    <= pixel_last_in;
            end else if ((state_q == WAIT) && bit_done_in && !pixel_done) begin
                shift_q   <= {shift_q[PIXEL_BITS-2:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    ws281x_latch_timer #(
        .CNT_W (RST_CNT_W)
    ) u_latch_timer (
        .clk      (clk_in),
        .rst      (rst_in),
        .load     (latch_load),
        .load_val (rst_cnt_in),
        .run      (state_q == LATCH),
        .expire   (latch_expire)
    );

    assign pixel_rdy_out  = (state_q == IDLE) || (state_q == LOAD);
    assign bit_rdy_out    = (state_q == SEND);
    // MSB of the shift register is the bit in flight; forced low while latching.
    assign bit_data_out   = ((state_q == SEND) || (state_q == WAIT)) && shift_q[PIXEL_BITS-1];
    assign frame_done_out = latch_expire;
    assign underrun_out   = (state_q == LOAD) && load_entry_q && !pixel_vld_in;
    assign busy_out       = (state_q != IDLE);

endmodule
